// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the 4:1 MUX scan sequencer.
package mux_scan_sequencer_pkg;

  // Two-state scan controller encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Channel select codes as driven onto {S1,S0}.
  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

  // Default settle time and counter width.
  localparam int SETTLE_DEFAULT = 1;
  localparam int CNT_W_DEFAULT  = 4;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Control/status bundle between the scan sequencer and its user plus the MUX.
//
// Handshake: start is a level sampled on every rising clk edge. It is acted on
// only when the sequencer is idle (busy=0); an accepted start raises busy on
// that same edge. Completion is a single-cycle done pulse, coincident with the
// cycle in which busy falls. A start with en=0 produces done alone.
interface mux_scan_sequencer_if;
  import mux_scan_sequencer_pkg::*;

  logic       start;
  logic [3:0] en;
  logic       y;
  logic       s1;
  logic       s0;
  logic [3:0] samples;
  logic       busy;
  logic       done;
  state_e     state;

  // Sequencer side.
  modport slave (
    input  start, en, y,
    output s1, s0, samples, busy, done, state
  );

  // Requester / MUX side.
  modport master (
    output start, en, y,
    input  s1, s0, samples, busy, done, state
  );
endinterface

// File: rtl/mux_scan_sequencer_chan_next_finder.sv
// Combinational search for the next enabled channel in ascending order.
// With from_none set it returns the lowest set bit of mask; otherwise the
// lowest set bit strictly above cur. has_next reports whether one exists.
module mux_scan_sequencer_chan_next_finder
  import mux_scan_sequencer_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  input  logic       from_none,
  output logic [1:0] next_ch,
  output logic       has_next
);

  // Walk from the top down so the last hit is the lowest qualifying channel.
  always_comb begin
    next_ch  = cur;
    has_next = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (from_none || (i > int'(cur)))) begin
        next_ch  = 2'(i);
        has_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans the enabled inputs of a 4:1 MUX in ascending order, waits a settle
// time on each, captures Y per channel and pulses done at the end of a pass.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_scan_sequencer_if.slave   bus
);

  // The settle counter must be able to hold its reload value.
  generate
    if ((SETTLE_CYCLES < 0) || (SETTLE_CYCLES >= (1 << CNT_W))) begin : g_bad_settle
      $error("mux_scan_sequencer: SETTLE_CYCLES does not fit in CNT_W bits");
    end
  endgenerate

  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES);

  state_e           state;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       mask_q;
  logic [3:0]       samples;
  logic             busy;
  logic             done;

  logic [1:0]       first_ch;
  logic             first_ok;
  logic [1:0]       next_ch;
  logic             has_next;

  // First channel of a new scan, taken straight from the live enable mask.
  mux_scan_sequencer_chan_next_finder u_first (
    .mask      (bus.en),
    .cur       (CH0),
    .from_none (1'b1),
    .next_ch   (first_ch),
    .has_next  (first_ok)
  );

  // Next channel within the running scan, from the latched mask.
  mux_scan_sequencer_chan_next_finder u_next (
    .mask      (mask_q),
    .cur       (sel),
    .from_none (1'b0),
    .next_ch   (next_ch),
    .has_next  (has_next)
  );

  // Scan FSM with settle counter, sample capture and done/busy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= CH0;
      cnt     <= '0;
      mask_q  <= 4'b0000;
      samples <= 4'b0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (first_ok) begin
              mask_q  <= bus.en;
              samples <= samples & bus.en;
              sel     <= first_ch;
              cnt     <= SETTLE_RELOAD;
              busy    <= 1'b1;
              state   <= ST_SCAN;
            end else begin
              // Empty mask: report completion without touching anything else.
              done <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            samples[sel] <= bus.y;
            if (has_next) begin
              sel <= next_ch;
              cnt <= SETTLE_RELOAD;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs come straight from registers.
  assign bus.s1      = sel[1];
  assign bus.s0      = sel[0];
  assign bus.samples = samples;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.state   = state;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: two sequencers (settle 1 and settle 0), each driving a
// behavioural 4:1 MUX whose output is looped back to Y.
module tb_mux_scan_sequencer;
  import mux_scan_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_scan_sequencer_if bus1 ();
  mux_scan_sequencer_if bus0 ();

  logic [3:0] i1 = 4'b0000;
  logic [3:0] i0 = 4'b0000;

  // Downstream MUX models.
  assign bus1.y = i1[{bus1.s1, bus1.s0}];
  assign bus0.y = i0[{bus0.s1, bus0.s0}];

  mux_scan_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] sel1();
    return {bus1.s1, bus1.s0};
  endfunction

  function automatic logic [1:0] sel0();
    return {bus0.s1, bus0.s0};
  endfunction

  logic [1:0] exp_sel[4];
  int         done_cnt;

  initial begin
    bus1.start = 1'b0; bus1.en = 4'b0000;
    bus0.start = 1'b0; bus0.en = 4'b0000;

    // Reset values.
    tick(); tick();
    chk("rst_sel", 32'(sel1()), 32'h0);
    chk("rst_samples", 32'(bus1.samples), 32'h0);
    chk("rst_busy", 32'(bus1.busy), 32'h0);
    chk("rst_done", 32'(bus1.done), 32'h0);
    chk("rst_state", 32'(bus1.state), 32'(ST_IDLE));
    chk("rst_busy0", 32'(bus0.busy), 32'h0);
    rst = 1'b0;
    tick();

    // 1: full scan, settle 1, inputs 1010.
    i1 = 4'b1010; bus1.en = 4'b1111; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("t1_sel", 32'(sel1()), 32'(c / 2));
      chk("t1_busy", 32'(bus1.busy), 32'h1);
      chk("t1_done_early", 32'(bus1.done), 32'h0);
      tick();
    end
    chk("t1_done", 32'(bus1.done), 32'h1);
    chk("t1_busy_fall", 32'(bus1.busy), 32'h0);
    chk("t1_samples", 32'(bus1.samples), 32'hA);
    chk("t1_sel_hold", 32'(sel1()), 32'h3);
    tick();
    chk("t1_done_pulse", 32'(bus1.done), 32'h0);

    // 3: empty mask gives done next cycle and nothing else.
    bus1.en = 4'b0000; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    chk("t3_done", 32'(bus1.done), 32'h1);
    chk("t3_busy", 32'(bus1.busy), 32'h0);
    chk("t3_state", 32'(bus1.state), 32'(ST_IDLE));
    chk("t3_samples", 32'(bus1.samples), 32'hA);
    chk("t3_sel_hold", 32'(sel1()), 32'h3);
    tick();
    chk("t3_done_pulse", 32'(bus1.done), 32'h0);

    // 2: preset samples to 1111, then scan 0101 with inputs 0000.
    i1 = 4'b1111; bus1.en = 4'b1111; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("t2_preset", 32'(bus1.samples), 32'hF);
    i1 = 4'b0000; bus1.en = 4'b0101; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    chk("t2_cleared", 32'(bus1.samples), 32'h5);
    exp_sel[0] = 2'd0; exp_sel[1] = 2'd0; exp_sel[2] = 2'd2; exp_sel[3] = 2'd2;
    for (int c = 0; c < 4; c++) begin
      chk("t2_sel", 32'(sel1()), 32'(exp_sel[c]));
      chk("t2_done_early", 32'(bus1.done), 32'h0);
      tick();
    end
    chk("t2_done", 32'(bus1.done), 32'h1);
    chk("t2_samples", 32'(bus1.samples), 32'h0);

    // 4: restart attempt and mask change mid-scan are ignored.
    i1 = 4'b0100; bus1.en = 4'b1100; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    exp_sel[0] = 2'd2; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd3;
    for (int c = 0; c < 4; c++) begin
      chk("t4_sel", 32'(sel1()), 32'(exp_sel[c]));
      chk("t4_done_early", 32'(bus1.done), 32'h0);
      if (c == 0) begin
        bus1.start = 1'b1;
        bus1.en    = 4'b0001;
      end
      if (c == 2) bus1.start = 1'b0;
      tick();
    end
    chk("t4_done", 32'(bus1.done), 32'h1);
    chk("t4_samples", 32'(bus1.samples), 32'h4);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus1.done) done_cnt++;
    end
    chk("t4_single_done", 32'(done_cnt), 32'h0);
    chk("t4_idle", 32'(bus1.busy), 32'h0);

    // 5: reset during channel 2 of a full scan.
    i1 = 4'b1111; bus1.en = 4'b1111; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("t5_sel_ch2", 32'(sel1()), 32'h2);
    chk("t5_partial", 32'(bus1.samples), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_sel", 32'(sel1()), 32'h0);
    chk("t5_samples", 32'(bus1.samples), 32'h0);
    chk("t5_busy", 32'(bus1.busy), 32'h0);
    chk("t5_done", 32'(bus1.done), 32'h0);
    chk("t5_state", 32'(bus1.state), 32'(ST_IDLE));
    tick();
    chk("t5_no_done", 32'(bus1.done), 32'h0);

    // 6: settle 0, one cycle per channel, then back-to-back restart.
    i0 = 4'b0110; bus0.en = 4'b1111; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t6_sel", 32'(sel0()), 32'(c));
      chk("t6_done_early", 32'(bus0.done), 32'h0);
      if (c == 3) begin
        bus0.start = 1'b1;
        bus0.en    = 4'b1000;
      end
      tick();
    end
    chk("t6_done", 32'(bus0.done), 32'h1);
    chk("t6_busy_fall", 32'(bus0.busy), 32'h0);
    chk("t6_samples", 32'(bus0.samples), 32'h6);
    i0 = 4'b1001;
    tick();
    bus0.start = 1'b0;
    chk("t6_restart_busy", 32'(bus0.busy), 32'h1);
    chk("t6_restart_sel", 32'(sel0()), 32'h3);
    chk("t6_restart_done", 32'(bus0.done), 32'h0);
    tick();
    chk("t6_done2", 32'(bus0.done), 32'h1);
    chk("t6_samples2", 32'(bus0.samples), 32'h8);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
